// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, S_TICK oversampling, mid-bit sampling,
// one-clk done / framing-error pulses.
module uart_rx #(
    parameter int NB_DATA = 8,
    parameter int S_TICK  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_tick,
    input  logic               rx_serial,
    output logic [NB_DATA-1:0] data_out,
    output logic               rx_done_tick,
    output logic               frame_error
);
    localparam int TW = $clog2(S_TICK);
    localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [TW-1:0] T_HALF = TW'(S_TICK / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(S_TICK - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NB_DATA - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_n;
    logic [TW-1:0]      tick_cnt, tick_n;
    logic [BW-1:0]      bit_cnt, bit_n;
    logic [NB_DATA-1:0] shift, shift_n;
    logic [NB_DATA-1:0] data_n;
    logic               armed, armed_n;
    logic               done_n, ferr_n;
    logic               rx_meta, rx_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            data_out     <= '0;
            armed        <= 1'b1;
            rx_done_tick <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            rx_meta      <= rx_serial;
            rx_s         <= rx_meta;
            state        <= state_n;
            tick_cnt     <= tick_n;
            bit_cnt      <= bit_n;
            shift        <= shift_n;
            data_out     <= data_n;
            armed        <= armed_n;
            rx_done_tick <= done_n;
            frame_error  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        data_n  = data_out;
        armed_n = armed;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                // Start edge detection runs every clk; only counting waits for s_tick.
                if (rx_s) armed_n = 1'b1;
                if (armed && !rx_s) begin
                    state_n = START;
                    tick_n  = '0;
                end
            end
            START: if (s_tick) begin
                if (tick_cnt == T_HALF) begin
                    tick_n = '0;
                    if (!rx_s) begin
                        state_n = DATA;
                        bit_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end
            DATA: if (s_tick) begin
                if (tick_cnt == T_LAST) begin
                    shift_n = {rx_s, shift[NB_DATA-1:1]};
                    tick_n  = '0;
                    if (bit_cnt == B_LAST) state_n = STOP;
                    else                   bit_n   = bit_cnt + 1'b1;
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end
            STOP: if (s_tick) begin
                if (tick_cnt == T_LAST) begin
                    state_n = IDLE;
                    tick_n  = '0;
                    if (rx_s) begin
                        data_n = shift;
                        done_n = 1'b1;
                    end else begin
                        // Disarm so a held-low break reports only one error.
                        ferr_n  = 1'b1;
                        armed_n = 1'b0;
                    end
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven serially, expected pulses queued
// at send time and checked by a monitor when the DUT pulses.
module tb_uart_rx;
    localparam int NB = 8;
    localparam int ST = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_tick = 1'b0;
    logic          rx_serial = 1'b1;
    logic [NB-1:0] data_out;
    logic          rx_done_tick;
    logic          frame_error;

    int vectors = 0, miscompares = 0;
    int tick_div = 1, div_cnt = 0, ticks = 0;
    int done_cnt = 0, err_cnt = 0;

    typedef struct {
        bit          is_err;
        logic [NB-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    uart_rx #(.NB_DATA(NB), .S_TICK(ST)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx_serial(rx_serial),
        .data_out(data_out), .rx_done_tick(rx_done_tick), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (div_cnt >= tick_div - 1) begin
            div_cnt <= 0;
            s_tick  <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1;
            s_tick  <= 1'b0;
        end
        if (s_tick) ticks <= ticks + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rx_done_tick || frame_error) begin
            exp_t e;
            check("pulse_exclusive", {31'd0, rx_done_tick & frame_error}, 0);
            check("pulse_expected", {31'd0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, frame_error}, {31'd0, e.is_err});
                check("pulse_data", {24'd0, data_out}, {24'd0, e.data});
            end
            if (rx_done_tick) done_cnt++;
            if (frame_error)  err_cnt++;
        end
    end

    task automatic wait_ticks(input int n);
        int t0 = ticks;
        int bound = n * tick_div * 2 + 20;
        for (int i = 0; i < bound && ticks < t0 + n; i++) begin
            @(posedge clk);
            #1;
        end
        if (ticks < t0 + n) check("tick_timeout", {31'd0, ticks >= t0 + n}, 1);
    endtask

    task automatic send_bit(input logic v);
        rx_serial = v;
        wait_ticks(ST);
    endtask

    task automatic send_frame(input logic [NB-1:0] d, input logic stop);
        exp_t e;
        e.is_err = !stop;
        e.data   = stop ? d : data_out;
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < NB; i++) send_bit(d[i]);
        send_bit(stop);
        if (stop) rx_serial = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", {24'd0, data_out}, 0);
        check("reset_done", {31'd0, rx_done_tick}, 0);
        check("reset_ferr", {31'd0, frame_error}, 0);
        reset = 1'b1;
        wait_ticks(20);

        send_frame(8'hA5, 1'b1);
        wait_ticks(4);
        drain();
        check("a5_done_cnt", done_cnt, 1);
        check("a5_data", {24'd0, data_out}, 32'hA5);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_ticks(4);
        drain();
        check("b2b_done_cnt", done_cnt, 3);
        check("b2b_data", {24'd0, data_out}, 32'hFF);

        rx_serial = 1'b0;
        wait_ticks(4);
        rx_serial = 1'b1;
        wait_ticks(30);
        check("glitch_done_cnt", done_cnt, 3);
        check("glitch_err_cnt", err_cnt, 0);
        check("glitch_data", {24'd0, data_out}, 32'hFF);

        send_frame(8'h3C, 1'b0);
        wait_ticks(40);
        rx_serial = 1'b1;
        wait_ticks(30);
        drain();
        check("ferr_err_cnt", err_cnt, 1);
        check("ferr_done_cnt", done_cnt, 3);
        check("ferr_data", {24'd0, data_out}, 32'hFF);

        // 0x81 LSB first: start, bits 1,0,0,0, then reset halfway through bit 4.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rx_serial = 1'b0;
        wait_ticks(8);
        reset = 1'b0;
        rx_serial = 1'b1;
        #1;
        check("abort_data", {24'd0, data_out}, 0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_done", {31'd0, rx_done_tick}, 0);
        check("abort_ferr", {31'd0, frame_error}, 0);
        reset = 1'b1;
        wait_ticks(30);
        check("abort_done_cnt", done_cnt, 3);
        send_frame(8'h81, 1'b1);
        wait_ticks(4);
        drain();
        check("resend_done_cnt", done_cnt, 4);
        check("resend_data", {24'd0, data_out}, 32'h81);

        tick_div = 3;
        wait_ticks(10);
        send_frame(8'h5A, 1'b1);
        wait_ticks(4);
        drain();
        check("sparse_done_cnt", done_cnt, 5);
        check("sparse_data", {24'd0, data_out}, 32'h5A);
        check("final_err_cnt", err_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial-to-parallel UART receiver. It is the receive end of the link driven by the team's transmitter: 1 start bit (0), NB_DATA data bits LSB first, 1 stop bit (1), and an idle-high line. The block oversamples the line with the shared baud-rate generator tick (S_TICK ticks per bit) and samples each bit at mid-bit. It delivers each byte with a one-cycle done pulse and flags framing errors.

Parameters:
NB_DATA, 8, data bits per frame
S_TICK, 16, s_tick pulses per bit period (even, >= 4)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
s_tick  input  1  one-clk pulse from baud-rate generator, S_TICK per bit
rx_serial  input  1  asynchronous serial line, idle high
data_out  output  NB_DATA  last correctly framed byte, held until next good frame
rx_done_tick  output  1  one-clk pulse: new byte valid on data_out
frame_error  output  1  one-clk pulse: stop bit sampled 0

Behaviour:
- Reset (reset=0, async): state=IDLE, counters=0, shift reg=0, data_out=0, rx_done_tick=0, frame_error=0, synchronizer flops=1, armed=1.
- rx_serial passes through a 2-flop synchronizer (rx_s). All decisions use rx_s. Added latency is 2 clk.
- Tick counter is compared only on cycles with s_tick=1. Otherwise all state holds.
- IDLE: if armed and rx_s==0 -> START, tick_cnt=0. armed is set whenever rx_s==1 in IDLE.
- START, on s_tick:
  - if tick_cnt==S_TICK/2-1 and rx_s==0 -> DATA, tick_cnt=0, bit_cnt=0 (now aligned to mid-bit).
  - if tick_cnt==S_TICK/2-1 and rx_s==1 -> glitch; return to IDLE, nothing reported.
  - else tick_cnt+1.
- DATA, on s_tick:
  - if tick_cnt==S_TICK-1: shift reg = {rx_s, shift[NB_DATA-1:1]} (LSB first), tick_cnt=0.
  - if bit_cnt==NB_DATA-1 -> STOP, else bit_cnt+1.
  - else tick_cnt+1.
- STOP, on s_tick, when tick_cnt==S_TICK-1 (mid stop bit) -> IDLE, tick_cnt=0:
  - rx_s==1: data_out<=shift reg; rx_done_tick=1 next clk.
  - rx_s==0: frame_error=1 next clk; data_out unchanged; armed=0 (line must return high before the next start, so a held-low break yields exactly one error).
- rx_done_tick and frame_error are registered, high exactly one clk, and never high together.
- Frame latency: done pulse is 1 clk after the mid-stop-bit sample, i.e. ~(NB_DATA+1.5)*S_TICK ticks after the start edge plus 3 clk.
- A new start edge is accepted in the first IDLE cycle after STOP, so back-to-back frames from the transmitter are received without loss.
- Reset asserted mid-frame aborts immediately to reset values. No pulse is emitted.
- Counter widths: tick_cnt holds S_TICK-1; bit_cnt is clog2(NB_DATA) wide, minimum 1.

Test Plan:
- s_tick every clk, S_TICK=16. Send 0xA5 (line: 0,1,0,1,0,0,1,0,1,1, 16 clk each) -> rx_done_tick single pulse, data_out=0xA5, frame_error=0.
- Back-to-back 0x00 then 0xFF, no idle gap -> two rx_done_ticks ~160 clk apart. data_out=0x00, then 0xFF.
- Low glitch of 4 ticks on idle line -> returns to IDLE. No rx_done_tick or frame_error. data_out unchanged.
- Frame 0x3C with stop bit forced 0, then line held low 40 ticks, then high -> exactly one frame_error pulse. No rx_done_tick. data_out keeps previous value. No further activity until line high and a new start.
- reset pulled low during DATA bit 4 of 0x81, released, then 0x81 resent cleanly -> outputs 0 during reset, no pulse for the aborted frame, then data_out=0x81 with one rx_done_tick.
- s_tick every 3rd clk (sparse ticks), send 0x5A -> data_out=0x5A. Sampling points land at mid-bit (tick 8 of 16).
